alu4bit_checker: RTL and testbench

//  Hardware response checker for alu4bit: taps each issued (A,B,sel) vector, computes the golden

---
 rtl/alu4bit_pkg.sv | 20 ++
 rtl/alu4bit_golden.sv | 28 ++
 rtl/alu4bit_checker.sv | 156 +++++++++++++++
 tb/tb_alu4bit_checker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu4bit_pkg.sv
// Shared definitions for the alu4bit response checker: ALU opcodes and checker FSM states.
package alu4bit_pkg;

   localparam logic [2:0] OP_AND   = 3'b000;
   localparam logic [2:0] OP_OR    = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_XOR   = 3'b100;
   localparam logic [2:0] OP_SHL   = 3'b101;
   localparam logic [2:0] OP_SHR   = 3'b110;
   localparam logic [2:0] OP_PASSA = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } chk_state_e;

endpackage

// File: rtl/alu4bit_golden.sv
// Combinational golden model of alu4bit: (A, B, sel) -> expected result, all arithmetic mod 2^WIDTH.
module alu4bit_golden
   import alu4bit_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] golden
);

   always_comb begin
      golden = '0;
      unique case (sel)
         OP_AND:   golden = A & B;
         OP_OR:    golden = A | B;
         OP_ADD:   golden = A + B;
         OP_SUB:   golden = A - B;
         OP_XOR:   golden = A ^ B;
         OP_SHL:   golden = {A[WIDTH-2:0], 1'b0};
         OP_SHR:   golden = {1'b0, A[WIDTH-1:1]};
         OP_PASSA: golden = A;
         default:  golden = '0;
      endcase
   end

endmodule

// File: rtl/alu4bit_checker.sv
// Response checker beside alu4bit: delays golden results by LATENCY and compares with the DUT output.
// Build option ALU_CHK_STOP_ON_FAIL_EN ends the run on the first mismatch.
module alu4bit_checker
   import alu4bit_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int LATENCY     = 1,
   parameter int NUM_VECTORS = 8,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [2:0]       fail_sel,
   output logic [WIDTH-1:0] fail_exp,
   output logic [WIDTH-1:0] fail_got,
   output logic [1:0]       fsm_state
);

   localparam int IW = $clog2(NUM_VECTORS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Handshake: a vector is taken on any rising edge where in_valid is high, the FSM is in
   // RUN and fewer than NUM_VECTORS have been taken; there is no back-pressure to the source.

   chk_state_e       state_q, state_d;
   logic [IW-1:0]    issued_q;
   logic [WIDTH-1:0] golden;
   logic             accept, cmp_en, mismatch, first_fail;
   logic             pending, clear, flush;

   logic [LATENCY-1:0] vld_q;
   logic [2:0]         sel_q [LATENCY];
   logic [WIDTH-1:0]   exp_q [LATENCY];

   alu4bit_golden #(.WIDTH(WIDTH)) u_golden (
      .A      (A),
      .B      (B),
      .sel    (sel),
      .golden (golden)
   );

   assign accept     = in_valid && (state_q == ST_RUN) && (issued_q < IW'(NUM_VECTORS));
   assign cmp_en     = vld_q[LATENCY-1];
   assign mismatch   = cmp_en && (exp_q[LATENCY-1] != result);
   assign first_fail = mismatch && (err_cnt == '0);

   assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);
   assign pass      = done && (err_cnt == '0);
   assign fsm_state = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      flush   = 1'b0;
      // Anything still in flight below the last stage keeps DRAIN alive one more cycle.
      pending = 1'b0;
      for (int i = 0; i < LATENCY - 1; i++) pending = pending | vld_q[i];
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               clear   = 1'b1;
            end
         end
         ST_RUN: begin
            if (accept && (issued_q == IW'(NUM_VECTORS - 1))) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!pending) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef ALU_CHK_STOP_ON_FAIL_EN
      if (first_fail && busy) begin
         state_d = ST_DONE;
         flush   = 1'b1;
      end
`else
      flush = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issued_q <= '0;
      end else if (clear) begin
         issued_q <= '0;
      end else if (accept) begin
         issued_q <= issued_q + 1'b1;
      end
   end

   // The line shifts every cycle, so a result is compared exactly LATENCY edges after issue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            sel_q[i] <= '0;
            exp_q[i] <= '0;
         end
      end else if (clear || flush) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= accept;
         sel_q[0] <= sel;
         exp_q[0] <= golden;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            sel_q[i] <= sel_q[i-1];
            exp_q[i] <= exp_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chk_cnt  <= '0;
         err_cnt  <= '0;
         fail_sel <= '0;
         fail_exp <= '0;
         fail_got <= '0;
      end else if (clear) begin
         chk_cnt  <= '0;
         err_cnt  <= '0;
         fail_sel <= '0;
         fail_exp <= '0;
         fail_got <= '0;
      end else if (cmp_en) begin
         if (chk_cnt != CNT_MAX) chk_cnt <= chk_cnt + 1'b1;
         if (mismatch && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;
         if (first_fail) begin
            fail_sel <= sel_q[LATENCY-1];
            fail_exp <= exp_q[LATENCY-1];
            fail_got <= result;
         end
      end
   end

endmodule

// File: tb/tb_alu4bit_checker.sv
// Directed bench for alu4bit_checker: two instances (LATENCY 1 and 2) fed by a stand-in ALU with fault injection.
module tb_alu4bit_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic       corrupt;
   logic [3:0] A, B;
   logic [2:0] sel;
   logic [3:0] model_out, res1, res2, pipe2;

   logic       busy1, done1, pass1, busy2, done2, pass2;
   logic [7:0] chk1, err1, chk2, err2;
   logic [2:0] fsel1, fsel2;
   logic [3:0] fexp1, fgot1, fexp2, fgot2;
   logic [1:0] st1, st2;

   int checks = 0;
   int errors = 0;

   logic [3:0] va [8];
   logic [3:0] vb [8];
   logic [2:0] vs [8];
   logic       vc [8];

   always #5 clk = ~clk;

   // Stand-in for alu4bit; corrupt adds one to the true result.
   function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
      case (s)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd3:    return a - b;
         3'd4:    return a ^ b;
         3'd5:    return {a[2:0], 1'b0};
         3'd6:    return {1'b0, a[3:1]};
         default: return a;
      endcase
   endfunction

   assign model_out = ref_alu(A, B, sel) + {3'b000, corrupt};

   always @(posedge clk) begin
      res1  <= model_out;
      pipe2 <= model_out;
      res2  <= pipe2;
   end

   alu4bit_checker #(.WIDTH(4), .LATENCY(1), .NUM_VECTORS(8), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .A(A), .B(B), .sel(sel),
      .result(res1), .busy(busy1), .done(done1), .pass(pass1), .chk_cnt(chk1), .err_cnt(err1),
      .fail_sel(fsel1), .fail_exp(fexp1), .fail_got(fgot1), .fsm_state(st1)
   );

   alu4bit_checker #(.WIDTH(4), .LATENCY(2), .NUM_VECTORS(8), .CNT_W(8)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .A(A), .B(B), .sel(sel),
      .result(res2), .busy(busy2), .done(done2), .pass(pass2), .chk_cnt(chk2), .err_cnt(err2),
      .fail_sel(fsel2), .fail_exp(fexp2), .fail_got(fgot2), .fsm_state(st2)
   );

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] s, input logic c);
      @(negedge clk);
      in_valid = v;
      A        = a;
      B        = b;
      sel      = s;
      corrupt  = c;
   endtask

   task automatic do_start();
      @(negedge clk);
      start    = 1'b1;
      in_valid = 1'b0;
      corrupt  = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic set_vec(input int i, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] s, input logic c);
      va[i] = a;
      vb[i] = b;
      vs[i] = s;
      vc[i] = c;
   endtask

   task automatic load_basic();
      for (int i = 0; i < 8; i++) set_vec(i, 4'd7, 4'd5, 3'(i), 1'b0);
   endtask

   task automatic run_vectors(input bit gapped);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, va[i], vb[i], vs[i], vc[i]);
         if (gapped && i < 7) drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      end
   endtask

   task automatic wait_done(input int which, input string name);
      int n;
      n = 0;
      while ((((which == 1) ? done1 : done2) !== 1'b1) && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("FAIL %s_done_timeout: done still low after %0d cycles, required high", name, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; corrupt = 1'b0;
      A = '0; B = '0; sel = '0;
      #12;
      checks++; if ({busy1, done1, pass1} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {busy1, done1, pass1}); end
      checks++; if ({chk1, err1} !== 16'h0) begin errors++; $display("FAIL reset_counts: got %h required 0000", {chk1, err1}); end
      checks++; if ({fsel1, fexp1, fgot1, st1} !== 13'h0) begin errors++; $display("FAIL reset_fail_regs: got %h required 0", {fsel1, fexp1, fgot1, st1}); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_all_pass();
      load_basic();
      do_start();
      checks++; if (busy1 !== 1'b1 || st1 !== 2'd1) begin errors++; $display("FAIL t1_run: busy %b state %0d required 1/1", busy1, st1); end
      run_vectors(1'b0);
      drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      wait_done(1, "t1");
      checks++; if (pass1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL t1_pass: pass %b busy %b required 1/0", pass1, busy1); end
      checks++; if (chk1 !== 8'd8) begin errors++; $display("FAIL t1_chk_cnt: got %0d required 8", chk1); end
      checks++; if (err1 !== 8'd0) begin errors++; $display("FAIL t1_err_cnt: got %0d required 0", err1); end
      checks++; if (st1 !== 2'd3) begin errors++; $display("FAIL t1_state: got %0d required 3", st1); end
      wait_done(2, "t1_l2");
      checks++; if (pass2 !== 1'b1 || chk2 !== 8'd8) begin errors++; $display("FAIL t1_l2: pass %b chk %0d required 1/8", pass2, chk2); end
   endtask

   task automatic test_fault();
      load_basic();
      vc[2] = 1'b1;
      do_start();
      run_vectors(1'b0);
      drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      wait_done(1, "t2");
      wait_done(2, "t2_l2");
      checks++; if (err1 !== 8'd1) begin errors++; $display("FAIL t2_err_cnt: got %0d required 1", err1); end
      checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL t2_pass: got %b required 0", pass1); end
      checks++; if (fsel1 !== 3'd2 || fexp1 !== 4'd12 || fgot1 !== 4'd13) begin errors++; $display("FAIL t2_capture: sel %0d exp %0d got %0d required 2/12/13", fsel1, fexp1, fgot1); end
      checks++; if (fsel2 !== 3'd2 || fexp2 !== 4'd12 || fgot2 !== 4'd13) begin errors++; $display("FAIL t2_capture_l2: sel %0d exp %0d got %0d required 2/12/13", fsel2, fexp2, fgot2); end
`ifdef ALU_CHK_STOP_ON_FAIL_EN
      checks++; if (chk1 !== 8'd3) begin errors++; $display("FAIL t2_chk_cnt: got %0d required 3", chk1); end
`else
      checks++; if (chk1 !== 8'd8) begin errors++; $display("FAIL t2_chk_cnt: got %0d required 8", chk1); end
`endif
   endtask

   task automatic test_wrap();
      set_vec(0, 4'd15, 4'd1, 3'd2, 1'b0);
      set_vec(1, 4'd0,  4'd1, 3'd3, 1'b0);
      set_vec(2, 4'd8,  4'd0, 3'd5, 1'b0);
      set_vec(3, 4'd1,  4'd3, 3'd6, 1'b0);
      set_vec(4, 4'd15, 4'd15, 3'd0, 1'b0);
      set_vec(5, 4'd0,  4'd0, 3'd1, 1'b0);
      set_vec(6, 4'd9,  4'd6, 3'd4, 1'b0);
      set_vec(7, 4'd10, 4'd0, 3'd7, 1'b0);
      do_start();
      run_vectors(1'b0);
      drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      wait_done(1, "t3");
      wait_done(2, "t3_l2");
      checks++; if (err1 !== 8'd0 || pass1 !== 1'b1) begin errors++; $display("FAIL t3_wrap: err %0d pass %b required 0/1", err1, pass1); end
      checks++; if (chk1 !== 8'd8) begin errors++; $display("FAIL t3_chk_cnt: got %0d required 8", chk1); end
   endtask

   task automatic test_gapped();
      load_basic();
      do_start();
      run_vectors(1'b1);
      drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      checks++; if (done2 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL t4_done_early: l1 %b l2 %b required 0/0", done1, done2); end
      @(negedge clk);
      checks++; if (done2 !== 1'b0 || done1 !== 1'b1) begin errors++; $display("FAIL t4_done_plus1: l1 %b l2 %b required 1/0", done1, done2); end
      @(negedge clk);
      checks++; if (done2 !== 1'b1 || pass2 !== 1'b1) begin errors++; $display("FAIL t4_done_plus2: done %b pass %b required 1/1", done2, pass2); end
      checks++; if (chk2 !== 8'd8 || err2 !== 8'd0) begin errors++; $display("FAIL t4_counts: chk %0d err %0d required 8/0", chk2, err2); end
   endtask

   task automatic test_async_reset();
      load_basic();
      do_start();
      for (int i = 0; i < 3; i++) drive(1'b1, va[i], vb[i], vs[i], vc[i]);
      drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      #2 rst = 1'b0;
      #1;
      checks++; if ({busy1, done1, pass1, st1} !== 5'b0) begin errors++; $display("FAIL t5_flags: got %b required 00000", {busy1, done1, pass1, st1}); end
      checks++; if ({chk1, err1, chk2, err2} !== 32'h0) begin errors++; $display("FAIL t5_counts: got %h required 0", {chk1, err1, chk2, err2}); end
      @(negedge clk);
      rst = 1'b1;
      do_start();
      run_vectors(1'b0);
      drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      wait_done(1, "t5");
      wait_done(2, "t5_l2");
      checks++; if (chk1 !== 8'd8 || err1 !== 8'd0 || pass1 !== 1'b1) begin errors++; $display("FAIL t5_rerun: chk %0d err %0d pass %b required 8/0/1", chk1, err1, pass1); end
   endtask

   task automatic test_back_to_back();
      load_basic();
      @(negedge clk);
      start = 1'b1; in_valid = 1'b1; A = 4'd7; B = 4'd5; sel = 3'd2; corrupt = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0; corrupt = 1'b0;
      for (int i = 0; i < 4; i++) drive(1'b1, va[i], vb[i], vs[i], vc[i]);
      @(negedge clk);
      start = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 4; i < 8; i++) drive(1'b1, va[i], vb[i], vs[i], vc[i]);
      drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      wait_done(1, "t7");
      wait_done(2, "t7_l2");
      checks++; if (chk1 !== 8'd8 || err1 !== 8'd0) begin errors++; $display("FAIL t7_restart: chk %0d err %0d required 8/0", chk1, err1); end
      drive(1'b1, 4'd7, 4'd5, 3'd2, 1'b1);
      drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      checks++; if (chk1 !== 8'd8 || err1 !== 8'd0 || done1 !== 1'b1) begin errors++; $display("FAIL t7_done_ignore: chk %0d err %0d done %b required 8/0/1", chk1, err1, done1); end
   endtask

   task automatic test_stop_on_fail();
      load_basic();
      vc[2] = 1'b1;
      vc[4] = 1'b1;
      do_start();
      run_vectors(1'b0);
      drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      wait_done(1, "t6");
      wait_done(2, "t6_l2");
      checks++; if (fsel1 !== 3'd2 || fexp1 !== 4'd12 || fgot1 !== 4'd13 || pass1 !== 1'b0) begin errors++; $display("FAIL t6_capture: sel %0d exp %0d got %0d pass %b required 2/12/13/0", fsel1, fexp1, fgot1, pass1); end
`ifdef ALU_CHK_STOP_ON_FAIL_EN
      checks++; if (chk1 !== 8'd3 || err1 !== 8'd1) begin errors++; $display("FAIL t6_stop: chk %0d err %0d required 3/1", chk1, err1); end
      checks++; if (chk2 !== 8'd3 || err2 !== 8'd1) begin errors++; $display("FAIL t6_stop_l2: chk %0d err %0d required 3/1", chk2, err2); end
`else
      checks++; if (chk1 !== 8'd8 || err1 !== 8'd2) begin errors++; $display("FAIL t6_total: chk %0d err %0d required 8/2", chk1, err1); end
      checks++; if (chk2 !== 8'd8 || err2 !== 8'd2) begin errors++; $display("FAIL t6_total_l2: chk %0d err %0d required 8/2", chk2, err2); end
`endif
   endtask

   initial begin
      test_reset();
      test_all_pass();
      test_fault();
      test_wrap();
      test_gapped();
      test_async_reset();
      test_back_to_back();
      test_stop_on_fail();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
